// File: rtl/mdu_ctrl.sv
// HI/LO owner for the MIPS multiply/divide unit: fixed-latency multiply,
// 32-step restoring divide with sign fix-up, MTHI/MTLO writes and flush cancel.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DIV_ITER = 32;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [63:0]  prod_q, prod_d;
  logic [31:0]  rem_q, rem_d;
  logic [31:0]  quo_q, quo_d;
  logic [31:0]  dvsr_q, dvsr_d;
  logic         qneg_q, qneg_d;
  logic         rneg_q, rneg_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  logic         done_q, done_d;

  logic                accept;
  logic                div_sx;
  logic signed [63:0]  mul_a, mul_b, mul_p;
  logic [32:0]         shifted, diff;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  assign accept = (state_q == S_IDLE) && start && !flush &&
                  (op != OP_NONE) && (op != OP_RSVD);
  assign div_sx = (op == OP_DIV);

  // Sign-extend to 64 bits so one signed multiplier serves MULT and MULTU.
  assign mul_a = {{32{(op == OP_MULT) & a[31]}}, a};
  assign mul_b = {{32{(op == OP_MULT) & b[31]}}, b};
  assign mul_p = mul_a * mul_b;

  // Dividend bits stream out of quo_q MSB-first while quotient bits enter at the LSB.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              prod_d  = mul_p;
              cnt_d   = MUL_LOAD;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              rem_d   = '0;
              quo_d   = mag(a, div_sx);
              dvsr_d  = mag(b, div_sx);
              qneg_d  = div_sx & (a[31] ^ b[31]);
              rneg_d  = div_sx & a[31];
              cnt_d   = DIV_LOAD;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_DFIX;
          else             cnt_d   = cnt_q - 5'd1;
        end
      end

      S_DFIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          lo_d   = neg_if(quo_q, qneg_q);
          hi_d   = neg_if(rem_q, rneg_q);
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name:
mdu_ctrl

Overview:
Multiply/divide sequencer for the 5-stage MIPS pipeline. Owns the HI/LO registers and sequences an iterative radix-2 divider and a fixed-latency multiplier for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Issued from EX. Drives `busy` into the hazard/stall logic so that MFHI/MFLO and further MDU ops wait. Accepts `flush` from the exception/ERET path to cancel an in-flight op.

Parameters:
MUL_CYCLES, 5, cycles `busy` is held for a multiply (legal range 1..15)
DIV_ITER, 32, divider iterations, one quotient bit per cycle (fixed at 32, not for override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  issue strobe from EX, sampled on rising edge
op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  input  32  rt operand (divisor / multiplier)
flush  input  1  cancel in-flight op (exception or ERET)
busy  output  1  op in progress; stall MFHI/MFLO and MDU issue
done  output  1  one-cycle pulse when HI/LO are updated by a MUL/DIV
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, hi=0, lo=0; counter, partial remainder and quotient are cleared. Reset mid-operation aborts the op and drops the result.
- States: IDLE, MUL, DIV, DFIX.
- Acceptance: accepted only when state=IDLE, start=1, flush=0, and op is in 001..110. In all other cases start is ignored. start while busy=1 is a protocol violation and the bench asserts on it.
- MTHI/MTLO: hi or lo is written with `a` on the accepting edge. The new value is visible the next cycle. No busy, no done.
- MULT/MULTU, accepted at edge E0:
  - The 64-bit product is registered at E0. Signed product for MULT, unsigned for MULTU.
  - State goes to MUL; the counter loads MUL_CYCLES-1.
  - busy=1 for exactly MUL_CYCLES cycles.
  - On the edge where the counter reaches 0: {hi,lo} is loaded with the product, done=1 for the following cycle, busy=0, state returns to IDLE.
- DIV/DIVU, accepted at E0:
  - Operands are latched as magnitudes. For DIV, |a| and |b| are taken; the quotient-negative flag is a[31]^b[31] and the remainder-negative flag is a[31].
  - DIV state: 32 restoring iterations, one per cycle, MSB first. Each iteration shifts the 33-bit partial remainder left by one and subtracts the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - DFIX: one cycle that applies sign correction. lo=quotient, hi=remainder (two's-complement negated where the flags require).
  - busy=1 for 33 cycles (32 DIV + 1 DFIX). hi/lo update on the DFIX exit edge; done pulses the next cycle.
- Divide by zero: no trap. The iteration runs unmodified with the same 33-cycle latency. Result is lo=32'hFFFF_FFFF, hi=a (DIVU) and, for DIV, the same magnitudes after sign correction.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0 (natural two's-complement wrap).
- flush while busy: state returns to IDLE on the next edge; busy=0 from that cycle; hi/lo unchanged; no done.
- flush with start in the same IDLE cycle: flush wins and the op is not accepted, including MTHI/MTLO.
- hi/lo stay stable and readable while busy. The consumer must not read them, because busy stalls MFHI/MFLO.
- done is never asserted in the same cycle as busy.

Test Plan:
- MULT a=0xFFFF_FFFD (-3), b=7 -> busy 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, done 1 cycle. MULTU with same operands -> hi=0x0000_0006, lo=0xFFFF_FFEB.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> busy 33 cycles, lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> 33 cycles, lo=0xFFFF_FFFF, hi=0x1234. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Preload via MTHI 0xAAAA_AAAA and MTLO 0x5555_5555, start DIV, flush at busy cycle 10 -> busy low next cycle, no done, hi/lo keep the preload values. Then a new MULT is accepted immediately.
- start with op=101 while busy -> ignored, hi unchanged. start together with flush in IDLE -> ignored. op=111 or op=000 with start -> ignored, busy stays 0.
- Assert rst during DIV cycle 20 -> outputs 0 immediately (async). After rst deasserts, MULT 3*4 -> lo=12, hi=0 after MUL_CYCLES.
